// File: rtl/sn_to_bn_counter_if.sv
// Stream/result bundle between the stochastic lanes and the stochastic-to-binary decoder.
// master drives the bit-streams, slave (the decoder) returns the per-window counts.
interface sn_to_bn_counter_if #(
    parameter int unsigned LANES = 4,
    parameter int unsigned CNT_W = 5
);
    logic             i_isgen;
    logic             i_sn_bit [LANES];
    logic             i_abort;
    logic [CNT_W-1:0] o_x_bn   [LANES];
    logic [CNT_W-1:0] o_len;
    logic             o_valid;
    logic             o_busy;

    modport master (
        output i_isgen, i_sn_bit, i_abort,
        input  o_x_bn, o_len, o_valid, o_busy
    );

    modport slave (
        input  i_isgen, i_sn_bit, i_abort,
        output o_x_bn, o_len, o_valid, o_busy
    );
endinterface

// File: rtl/sn_to_bn_counter.sv
// Stochastic-to-binary decoder: counts ones per lane over a window of up to STREAM_LEN
// strobed bits and registers the counts and window length with a one-cycle valid pulse.
module sn_to_bn_counter #(
    parameter int unsigned LANES      = 4,
    parameter int unsigned STREAM_LEN = 16,
    parameter int unsigned CNT_W      = 5
) (
    input logic              i_clk_fsm_mux,
    input logic              i_rst_fsm_mux,
    sn_to_bn_counter_if.slave bus
);
    generate
        if (CNT_W != $clog2(STREAM_LEN + 1)) begin : g_bad_cnt_w
            $error("CNT_W must equal clog2(STREAM_LEN+1)");
        end
    endgenerate

    typedef enum logic {IDLE, ACC} state_t;

    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(STREAM_LEN - 1);
    localparam logic [CNT_W-1:0] FULL_LEN = CNT_W'(STREAM_LEN);

    state_t           state;
    logic [CNT_W-1:0] acc     [LANES];
    logic [CNT_W-1:0] bcnt;
    logic [CNT_W-1:0] x_bn_q  [LANES];
    logic [CNT_W-1:0] len_q;
    logic             valid_q;
    logic             busy_q;

    always_ff @(posedge i_clk_fsm_mux or posedge i_rst_fsm_mux) begin
        if (i_rst_fsm_mux) begin
            state   <= IDLE;
            bcnt    <= '0;
            len_q   <= '0;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
            for (int unsigned l = 0; l < LANES; l++) begin
                acc[l]    <= '0;
                x_bn_q[l] <= '0;
            end
        end else begin
            valid_q <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.i_isgen && !bus.i_abort) begin
                        for (int unsigned l = 0; l < LANES; l++)
                            acc[l] <= CNT_W'(bus.i_sn_bit[l]);
                        bcnt   <= CNT_W'(1);
                        state  <= ACC;
                        busy_q <= 1'b1;
                    end
                end
                ACC: begin
                    if (bus.i_abort) begin
                        for (int unsigned l = 0; l < LANES; l++) acc[l] <= '0;
                        bcnt   <= '0;
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end else if (!bus.i_isgen) begin
                        for (int unsigned l = 0; l < LANES; l++) begin
                            x_bn_q[l] <= acc[l];
                            acc[l]    <= '0;
                        end
                        len_q   <= bcnt;
                        valid_q <= 1'b1;
                        bcnt    <= '0;
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                    end else if (bcnt == LAST_IDX) begin
                        // Final bit folds straight into the output register.
                        for (int unsigned l = 0; l < LANES; l++) begin
                            x_bn_q[l] <= acc[l] + CNT_W'(bus.i_sn_bit[l]);
                            acc[l]    <= '0;
                        end
                        len_q   <= FULL_LEN;
                        valid_q <= 1'b1;
                        bcnt    <= '0;
                        state   <= IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        for (int unsigned l = 0; l < LANES; l++)
                            acc[l] <= acc[l] + CNT_W'(bus.i_sn_bit[l]);
                        bcnt <= bcnt + CNT_W'(1);
                    end
                end
            endcase
        end
    end

    assign bus.o_x_bn  = x_bn_q;
    assign bus.o_len   = len_q;
    assign bus.o_valid = valid_q;
    assign bus.o_busy  = busy_q;
endmodule

// File: doc/sn_to_bn_counter.md
# sn_to_bn_counter

Stochastic-to-binary decoder: the receive end of the 4-lane stochastic bit-stream interface driven by the binary-to-stochastic generator. It counts ones per lane over a bounded window of up to STREAM_LEN bits qualified by a stream-valid strobe. At the end of each window it registers one binary count per lane, plus the window length, with a single-cycle valid pulse. It sits after the stochastic compute lanes (AND/MUX arithmetic) and feeds binary results back to the layer datapath.

## Interface
- LANES, 4, number of parallel bit-stream lanes
- STREAM_LEN, 16, maximum bits per window
- CNT_W, 5, count width; must equal clog2(STREAM_LEN+1)
- i_clk_fsm_mux  in  1  clock; all state is updated on the rising edge
- i_rst_fsm_mux  in  1  asynchronous, active-high reset
- i_isgen  in  1  stream valid; `i_sn_bit` is sampled on every edge where it is 1
- i_sn_bit  in  1 x LANES (unpacked)  one stochastic bit per lane
- i_abort  in  1  discard the current window; highest priority after reset
- o_x_bn  out  CNT_W x LANES (unpacked)  per-lane ones count of the last completed window
- o_len  out  CNT_W  bits accepted in the last completed window (1..STREAM_LEN)
- o_valid  out  1  one-cycle pulse: new `o_x_bn`/`o_len` are present this cycle
- o_busy  out  1  high while a window is open (state ACC)

## Operation
- State machine: IDLE and ACC.
- Internal registers: per-lane accumulators `acc[l]` (CNT_W bits), bit counter `bcnt` (CNT_W bits), and output registers.
- **IDLE**
  - `i_isgen`=1 and `i_abort`=0: `acc[l]`=`i_sn_bit[l]`, `bcnt`=1, go to ACC.
  - Otherwise: hold.
- **ACC**, evaluated in priority order each edge:
  1. `i_abort`=1: clear `acc` and `bcnt`, go to IDLE. No `o_valid`; outputs hold their previous values.
  2. `i_isgen`=0: close the window.
     - `o_x_bn[l]`=`acc[l]`, `o_len`=`bcnt`, `o_valid`=1.
     - Go to IDLE.
  3. `i_isgen`=1 and `bcnt`<STREAM_LEN−1: `acc[l]`+=`i_sn_bit[l]`, `bcnt`+=1.
  4. `i_isgen`=1 and `bcnt`=STREAM_LEN−1: this is the final bit.
     - `o_x_bn[l]`=`acc[l]`+`i_sn_bit[l]`, `o_len`=STREAM_LEN, `o_valid`=1.
     - Clear `acc` and `bcnt`, go to IDLE.
- Arithmetic: unsigned addition; the count cannot exceed STREAM_LEN, so no overflow is possible and there is no saturation logic.
- `o_x_bn` and `o_len` hold until the next completed window.
- An empty window cannot occur: a window always opens with one accepted bit.
- Reset (asynchronous, any time, including mid-window):
  - state IDLE;
  - `acc`, `bcnt`, `o_x_bn`, `o_len` all 0;
  - `o_valid` 0, `o_busy` 0.

## Timing
- Each bit is accepted at the rising edge where `i_isgen`=1.
- Full window: the 16th accepted bit's edge updates `o_x_bn`/`o_len`. `o_valid` is high during the following cycle only (latency 1 cycle from the last bit).
- Early close: at the first edge with `i_isgen`=0, the results are registered. `o_valid` is high the next cycle.
- Back-to-back windows: if `i_isgen` stays high past a full window, the next edge is accepted in IDLE as bit 1 of a new window. There are no bubbles; `o_valid` pulses every STREAM_LEN cycles.
- Simultaneous events:
  - `i_abort` together with the final bit: abort wins and no `o_valid` is produced.
  - `i_abort` in IDLE together with `i_isgen`: the bit is not accepted.
- `o_busy` is 1 exactly while the state is ACC. It is 0 in the cycle `o_valid` is high, unless a back-to-back window has already opened.

## Test plan
- **Encoder stream.** Drive 16 cycles of `i_isgen`=1, with lanes carrying generator patterns for binary {15,10,5,0} (last bit 0).
  Required: one `o_valid` pulse, `o_x_bn`={15,10,5,0}, `o_len`=16.
- **Early close.** Drive `i_isgen`=1 for 6 cycles with lane0=1 and other lanes=0, then drop `i_isgen`.
  Required: `o_valid` one cycle after the drop edge, `o_x_bn`={6,0,0,0}, `o_len`=6.
- **Back-to-back.** Drive 32 consecutive `i_isgen` cycles: all-ones for the first 16, all-zeros for the next 16.
  Required: two `o_valid` pulses exactly 16 cycles apart; values {16,16,16,16} then {0,0,0,0}; `o_len`=16 both times.
- **Abort.** After a completed window giving {3,3,3,3}, start a new window and assert `i_abort` on bit 8 (also repeat with `i_abort` on bit 16).
  Required: no `o_valid`, outputs stay {3,3,3,3}, state IDLE. The next full window decodes correctly.
- **Reset mid-window.** Assert `i_rst_fsm_mux` asynchronously between edges at bit 5 of a window.
  Required: `o_x_bn`=0, `o_len`=0, `o_busy`=0 immediately. The next window after release decodes correctly.
- **Idle noise.** Toggle `i_sn_bit` with `i_isgen`=0 for 20 cycles.
  Required: no `o_valid`, `o_busy`=0, outputs unchanged.
